pru_cmd_sched: RTL
==================

PRU_CMD_SCHED -- requirements
Module: pru_cmd_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command queue entries (power of two, >=2).
REQ-002 SHALL have parameter TIMEOUT, default 65535, maximum cycles to wait for PRU done before aborting.
REQ-003 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports cmd_valid input 1 / cmd_ready output 1  command push handshake.
REQ-006 SHALL have command inputs cmd_color 2, cmd_row 10, cmd_col 9, cmd_width 10, cmd_height_radius 9, cmd_shape 2, cmd_subtract 1  draw command fields.
REQ-007 SHALL have outputs color 2, row 10, col 9, width 10, height_radius 9, shape_select 2, subtract 1, start 1  registered drive to the PRU.
REQ-008 SHALL have inputs busy 1, done 1  PRU status.
REQ-009 SHALL have inputs flush 1, err_clr 1; outputs queue_count $clog2(DEPTH)+1, idle 1, err_timeout 1.

Function
REQ-010 SHALL accept a command at a rising edge where cmd_valid && cmd_ready; cmd_ready = (queue_count < DEPTH), combinational from count only.
REQ-011 SHALL store commands in FIFO order; a push while full SHALL be impossible (ready=0); no command is ever dropped or reordered.
REQ-012 SHALL implement FSM IDLE, ISSUE, WAIT_DONE.
REQ-013 IDLE: if queue_count>0 and flush=0, pop head into PRU output registers, set start=1, go ISSUE; else stay.
REQ-014 ISSUE: hold start=1 and all PRU outputs stable; on busy=1 or done=1 sampled, start=0, go WAIT_DONE.
REQ-015 WAIT_DONE: PRU outputs stay stable; on done=1 go IDLE; next pop occurs no earlier than the following edge.
REQ-016 Latency: command pushed at edge N into an empty queue with FSM in IDLE SHALL produce start=1 in the cycle after edge N+1.
REQ-017 Simultaneous push and pop in one edge SHALL leave queue_count unchanged and both operations effective.
REQ-018 A 16-bit watchdog SHALL clear on entering ISSUE and count each cycle in ISSUE/WAIT_DONE; reaching TIMEOUT SHALL force start=0, go IDLE, set err_timeout.
REQ-019 err_timeout SHALL be sticky until err_clr=1; err_clr and a new timeout in the same edge: set wins.
REQ-020 flush=1 SHALL empty the queue at that edge (a same-edge push is discarded) and SHALL NOT abort an in-flight command.
REQ-021 idle SHALL be 1 iff FSM in IDLE and queue_count==0.
REQ-022 PRU output registers SHALL change only on a pop; between commands they retain the last command values.

Reset
REQ-023 rst_n=0 SHALL asynchronously force FSM to IDLE, queue_count=0, read/write pointers=0, watchdog=0, err_timeout=0.
REQ-024 During reset all PRU outputs (color,row,col,width,height_radius,shape_select,subtract,start) SHALL be 0; idle=1, cmd_ready=1.
REQ-025 Reset mid-command SHALL discard the in-flight and queued commands; no start pulse after deassertion until a new push.

Structure
REQ-026 Package pru_pkg SHALL hold shape enum (RECT=2'b00, CIRCLE=2'b01), packed struct pru_cmd_t of the seven command fields, and field-width constants.
REQ-027 The queue SHALL be a sub-module pru_cmd_fifo (DEPTH entries of pru_cmd_t, push/pop/flush, count); the FSM and watchdog live in pru_cmd_sched.

Verification
REQ-028 Push rect (color=1,row=10,col=10,width=15,h=15,shape=0); PRU model busy 2 cycles later, done after 20 -> start high exactly 1 cycle after push+1, outputs stable until done, idle=1 after.
REQ-029 Push rect then circle (color=2,row=30,col=30,h=10,shape=1) back-to-back -> circle start only after rect done; outputs switch to circle values on that pop.
REQ-030 Push 5 commands with PRU stalled, DEPTH=4 -> first popped, 4 queued, cmd_ready=0 on 6th attempt, queue_count=4, order preserved.
REQ-031 PRU model never asserts done, TIMEOUT=100 -> start drops, err_timeout=1 after 100 cycles, next command issued; err_clr returns err_timeout=0.
REQ-032 flush with 3 queued and one in flight -> queue_count=0 next cycle, in-flight completes, no further start.
REQ-033 rst_n low during WAIT_DONE with 2 queued -> all outputs 0 immediately, queue empty, no start after release.

Source files
------------

// File: rtl/pru_pkg.sv
// pru_pkg: shared types and field widths for the PRU command scheduler.
// Holds the shape encoding and the packed draw-command bundle.
package pru_pkg;

    localparam int COLOR_W = 2;
    localparam int ROW_W   = 10;
    localparam int COL_W   = 9;
    localparam int WIDTH_W = 10;
    localparam int HR_W    = 9;
    localparam int SHAPE_W = 2;

    typedef enum logic [SHAPE_W-1:0] {
        RECT   = 2'b00,
        CIRCLE = 2'b01
    } shape_e;

    typedef struct packed {
        logic [COLOR_W-1:0] color;
        logic [ROW_W-1:0]   row;
        logic [COL_W-1:0]   col;
        logic [WIDTH_W-1:0] width;
        logic [HR_W-1:0]    height_radius;
        logic [SHAPE_W-1:0] shape;
        logic               subtract;
    } pru_cmd_t;

endpackage

// File: rtl/pru_cmd_fifo.sv
// pru_cmd_fifo: DEPTH-entry FIFO of draw commands with synchronous flush.
// Ports: clk, rst_n; push/push_data, pop/pop_data (head); flush; count, ready.
module pru_cmd_fifo
    import pru_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  pru_cmd_t                 push_data,
    input  logic                     pop,
    input  logic                     flush,
    output pru_cmd_t                 pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    pru_cmd_t mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    // Flush wins over both operations in the same edge.
    assign ready    = (count < FULL);
    assign push_ok  = push && ready && !flush;
    assign pop_ok   = pop && (count != '0) && !flush;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pru_cmd_sched.sv
// pru_cmd_sched: queues draw commands and issues them one at a time to the
// PRU via start/busy/done, with a watchdog that aborts a stuck command.
// Ports: clk, rst_n; cmd_valid/cmd_ready + cmd_* (push side);
//   color..subtract, start (registered PRU drive); busy, done (PRU status);
//   flush, err_clr (control); queue_count, idle, err_timeout (status).
module pru_cmd_sched
    import pru_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [COLOR_W-1:0]     cmd_color,
    input  logic [ROW_W-1:0]       cmd_row,
    input  logic [COL_W-1:0]       cmd_col,
    input  logic [WIDTH_W-1:0]     cmd_width,
    input  logic [HR_W-1:0]        cmd_height_radius,
    input  logic [SHAPE_W-1:0]     cmd_shape,
    input  logic                   cmd_subtract,
    output logic [COLOR_W-1:0]     color,
    output logic [ROW_W-1:0]       row,
    output logic [COL_W-1:0]       col,
    output logic [WIDTH_W-1:0]     width,
    output logic [HR_W-1:0]        height_radius,
    output logic [SHAPE_W-1:0]     shape_select,
    output logic                   subtract,
    output logic                   start,
    input  logic                   busy,
    input  logic                   done,
    input  logic                   flush,
    input  logic                   err_clr,
    output logic [$clog2(DEPTH):0] queue_count,
    output logic                   idle,
    output logic                   err_timeout
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    // Watchdog fires on the TIMEOUT-th edge spent in ISSUE/WAIT.
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [15:0] wd;
    pru_cmd_t    push_cmd;
    pru_cmd_t    head_cmd;
    pru_cmd_t    cur;
    logic        pop;
    logic        running;
    logic        abort;

    assign push_cmd = '{
        color:         cmd_color,
        row:           cmd_row,
        col:           cmd_col,
        width:         cmd_width,
        height_radius: cmd_height_radius,
        shape:         cmd_shape,
        subtract:      cmd_subtract
    };

    pru_cmd_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_valid),
        .push_data (push_cmd),
        .pop       (pop),
        .flush     (flush),
        .pop_data  (head_cmd),
        .count     (queue_count),
        .ready     (cmd_ready)
    );

    assign pop     = (state == S_IDLE) && (queue_count != '0) && !flush;
    assign running = (state == S_ISSUE) || (state == S_WAIT);
    // A done arriving on the last WAIT cycle still completes normally.
    assign abort   = running && (wd == WD_LAST)
                     && !((state == S_WAIT) && done);
    assign idle    = (state == S_IDLE) && (queue_count == '0);

    assign color         = cur.color;
    assign row           = cur.row;
    assign col           = cur.col;
    assign width         = cur.width;
    assign height_radius = cur.height_radius;
    assign shape_select  = cur.shape;
    assign subtract      = cur.subtract;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cur         <= '0;
            start       <= 1'b0;
            wd          <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (abort) begin
                err_timeout <= 1'b1;
            end else if (err_clr) begin
                err_timeout <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (pop) begin
                        cur   <= head_cmd;
                        start <= 1'b1;
                        wd    <= '0;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (abort) begin
                        start <= 1'b0;
                        wd    <= '0;
                        state <= S_IDLE;
                    end else begin
                        wd <= wd + 16'd1;
                        if (busy || done) begin
                            start <= 1'b0;
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (abort) begin
                        wd    <= '0;
                        state <= S_IDLE;
                    end else if (done) begin
                        wd    <= '0;
                        state <= S_IDLE;
                    end else begin
                        wd <= wd + 16'd1;
                    end
                end
                default: begin
                    start <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
